// File: rtl/branch_update_unit_pkg.sv
// Shared predictor header: address/GHR/target widths, FSM encoding and checkpoint entry layout.
// Optional target checking is enabled by defining BRU_TARGET_CHK_EN.
`ifndef BRU_PRED_DEFS
`define BRU_PRED_DEFS
`define GHR_WIDTH 14
`define ADDR_WIDTH 32
`define TARGET_ADDR 32
`endif

package branch_update_unit_pkg;
  localparam int GHR_W   = `GHR_WIDTH;
  localparam int ADDR_W  = `ADDR_WIDTH;
  localparam int TAR_W   = `TARGET_ADDR;
  localparam int MPCNT_W = 16;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_RECOVER = 1'b1
  } bru_state_e;

  typedef struct packed {
`ifdef BRU_TARGET_CHK_EN
    logic [TAR_W-1:0]  tar;
`endif
    logic [ADDR_W-1:0] pc;
    logic              torn;
    logic [GHR_W-1:0]  ghr;
  } chk_entry_t;

  localparam int ENTRY_W = $bits(chk_entry_t);

  // The restored history includes the resolved outcome of the branch that mispredicted.
  function automatic logic [GHR_W-1:0] restore_ghr(input logic [GHR_W-1:0] ghr,
                                                   input logic torn);
    return {ghr[GHR_W-2:0], torn};
  endfunction
endpackage

// File: rtl/branch_update_unit_chk_fifo.sv
// Checkpoint FIFO: power-of-two depth, head exposed combinationally, flush empties it in one edge.
module chk_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [PW:0]   count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= wr_ptr_q;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end
endmodule

// File: rtl/branch_update_unit.sv
// Branch update unit: checkpoints predictions, checks them at resolve, drives PAs update and GHR recovery.
// Define BRU_TARGET_CHK_EN to also store and check predicted targets.
module branch_update_unit
  import branch_update_unit_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pred_valid,
  input  logic [ADDR_W-1:0]  pred_pc,
  input  logic               pred_torn,
  input  logic [GHR_W-1:0]   pred_ghr,
  output logic               pred_ready,
  input  logic               res_valid,
  input  logic               res_torn,
  output logic               res_ready,
  output logic               PAs_up_en,
  output logic               PAs_wr_data,
  output logic [ADDR_W-1:0]  upd_pc,
  output logic               gshare_reen,
  output logic [GHR_W-1:0]   re_GHR,
  output logic               mispredict,
  output logic [MPCNT_W-1:0] mp_cnt
`ifdef BRU_TARGET_CHK_EN
  ,
  input  logic [TAR_W-1:0]   pred_tar,
  input  logic [TAR_W-1:0]   res_tar,
  output logic [TAR_W-1:0]   up_addr,
  output logic               up_tar_en
`endif
);
  // Handshakes: an entry moves when valid && ready in the same cycle; ready never depends on valid.
  bru_state_e         state_q, state_d;
  chk_entry_t         head, wr_entry;
  logic               full, empty, push, pop, dir_miss, tar_miss, mp_now;
  logic               pas_up_en_q, pas_wr_data_q;
  logic [ADDR_W-1:0]  upd_pc_q;
  logic [GHR_W-1:0]   re_ghr_q;
  logic [MPCNT_W-1:0] mp_cnt_q;

  assign pred_ready = !full && (state_q == ST_IDLE);
  assign res_ready  = !empty && (state_q == ST_IDLE);
  assign pop        = res_valid && res_ready;
  assign dir_miss   = (res_torn != head.torn);
  assign mp_now     = pop && (dir_miss || tar_miss);
  // Predictions arriving alongside a mispredicting resolve are wrong-path.
  assign push       = pred_valid && pred_ready && !mp_now;

  assign wr_entry.pc   = pred_pc;
  assign wr_entry.torn = pred_torn;
  assign wr_entry.ghr  = pred_ghr;
`ifdef BRU_TARGET_CHK_EN
  assign wr_entry.tar  = pred_tar;
  assign tar_miss      = res_torn && (res_tar != head.tar);
`else
  assign tar_miss      = 1'b0;
`endif

  chk_fifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_chk_fifo (
    .clk_i   (clk),
    .reset_i (reset),
    .push_i  (push),
    .data_i  (wr_entry),
    .pop_i   (pop),
    .flush_i (mp_now),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (mp_now) state_d = ST_RECOVER;
      ST_RECOVER: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mispredict  = 1'b0;
    gshare_reen = 1'b0;
    if (state_q == ST_RECOVER) begin
      mispredict  = 1'b1;
      gshare_reen = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pas_up_en_q   <= 1'b0;
      pas_wr_data_q <= 1'b0;
      upd_pc_q      <= '0;
      re_ghr_q      <= '0;
      mp_cnt_q      <= '0;
    end else begin
      pas_up_en_q <= pop;
      if (pop) begin
        pas_wr_data_q <= res_torn;
        upd_pc_q      <= head.pc;
      end
      if (mp_now) begin
        re_ghr_q <= restore_ghr(head.ghr, res_torn);
        if (mp_cnt_q != '1) mp_cnt_q <= mp_cnt_q + 1'b1;
      end
    end
  end

  assign PAs_up_en   = pas_up_en_q;
  assign PAs_wr_data = pas_wr_data_q;
  assign upd_pc      = upd_pc_q;
  assign re_GHR      = re_ghr_q;
  assign mp_cnt      = mp_cnt_q;

`ifdef BRU_TARGET_CHK_EN
  logic             tar_upd_q;
  logic [TAR_W-1:0] up_addr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      tar_upd_q <= 1'b0;
      up_addr_q <= '0;
    end else begin
      tar_upd_q <= mp_now && tar_miss;
      if (mp_now && tar_miss) up_addr_q <= res_tar;
    end
  end

  assign up_tar_en = tar_upd_q && (state_q == ST_RECOVER);
  assign up_addr   = up_addr_q;
`endif
endmodule

// File: tb/tb_branch_update_unit.sv
// Directed bench for branch_update_unit: correct/mispredicted resolves, full/empty edges, saturation, reset.
module tb_branch_update_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pred_valid = 1'b0;
  logic [31:0] pred_pc = '0;
  logic        pred_torn = 1'b0;
  logic [13:0] pred_ghr = '0;
  logic        pred_ready;
  logic        res_valid = 1'b0;
  logic        res_torn = 1'b0;
  logic        res_ready;
  logic        PAs_up_en, PAs_wr_data;
  logic [31:0] upd_pc;
  logic        gshare_reen;
  logic [13:0] re_GHR;
  logic        mispredict;
  logic [15:0] mp_cnt;
`ifdef BRU_TARGET_CHK_EN
  logic [31:0] pred_tar = '0;
  logic [31:0] res_tar = '0;
  logic [31:0] up_addr;
  logic        up_tar_en;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  branch_update_unit #(.DEPTH(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .pred_valid  (pred_valid),
    .pred_pc     (pred_pc),
    .pred_torn   (pred_torn),
    .pred_ghr    (pred_ghr),
    .pred_ready  (pred_ready),
    .res_valid   (res_valid),
    .res_torn    (res_torn),
    .res_ready   (res_ready),
    .PAs_up_en   (PAs_up_en),
    .PAs_wr_data (PAs_wr_data),
    .upd_pc      (upd_pc),
    .gshare_reen (gshare_reen),
    .re_GHR      (re_GHR),
    .mispredict  (mispredict),
    .mp_cnt      (mp_cnt)
`ifdef BRU_TARGET_CHK_EN
    ,
    .pred_tar    (pred_tar),
    .res_tar     (res_tar),
    .up_addr     (up_addr),
    .up_tar_en   (up_tar_en)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [31:0] pc, input logic torn, input logic [13:0] ghr);
    pred_valid = 1'b1;
    pred_pc    = pc;
    pred_torn  = torn;
    pred_ghr   = ghr;
    step();
    pred_valid = 1'b0;
  endtask

  task automatic res(input logic torn);
    res_valid = 1'b1;
    res_torn  = torn;
    step();
    res_valid = 1'b0;
  endtask

  initial begin
    step();
    step();
    reset = 1'b0;
    #1;
    check("rst_pred_ready", 32'(pred_ready), 32'd1);
    check("rst_res_ready", 32'(res_ready), 32'd0);
    check("rst_pas_up_en", 32'(PAs_up_en), 32'd0);
    check("rst_mispredict", 32'(mispredict), 32'd0);
    check("rst_gshare_reen", 32'(gshare_reen), 32'd0);
    check("rst_mp_cnt", 32'(mp_cnt), 32'd0);
    check("rst_upd_pc", upd_pc, 32'd0);
    check("rst_re_ghr", 32'(re_GHR), 32'd0);

    // Correctly predicted taken branch.
    enq(32'h1000, 1'b1, 14'h0005);
    check("ok_res_ready", 32'(res_ready), 32'd1);
    res(1'b1);
    check("ok_pas_up_en", 32'(PAs_up_en), 32'd1);
    check("ok_pas_wr_data", 32'(PAs_wr_data), 32'd1);
    check("ok_upd_pc", upd_pc, 32'h1000);
    check("ok_mispredict", 32'(mispredict), 32'd0);
    check("ok_gshare_reen", 32'(gshare_reen), 32'd0);
    step();
    check("ok_pas_pulse_end", 32'(PAs_up_en), 32'd0);
    check("ok_empty_after", 32'(res_ready), 32'd0);

    // Mispredict with three entries; a same-cycle prediction must be dropped.
    enq(32'h2000, 1'b0, 14'h3FFF);
    enq(32'h2004, 1'b1, 14'h0001);
    enq(32'h2008, 1'b0, 14'h0002);
    pred_valid = 1'b1;
    pred_pc    = 32'h2100;
    pred_torn  = 1'b1;
    pred_ghr   = 14'h0010;
    res_valid  = 1'b1;
    res_torn   = 1'b1;
    step();
    res_valid = 1'b0;
    #1;
    check("mp_mispredict", 32'(mispredict), 32'd1);
    check("mp_gshare_reen", 32'(gshare_reen), 32'd1);
    check("mp_re_ghr", 32'(re_GHR), 32'h3FFF);
    check("mp_pred_ready", 32'(pred_ready), 32'd0);
    check("mp_res_ready", 32'(res_ready), 32'd0);
    check("mp_cnt_1", 32'(mp_cnt), 32'd1);
    check("mp_pas_up_en", 32'(PAs_up_en), 32'd1);
    check("mp_upd_pc", upd_pc, 32'h2000);
    check("mp_pas_wr_data", 32'(PAs_wr_data), 32'd1);
    step();
    pred_valid = 1'b0;
    #1;
    check("rec_end_mispredict", 32'(mispredict), 32'd0);
    check("rec_end_gshare_reen", 32'(gshare_reen), 32'd0);
    check("rec_end_fifo_empty", 32'(res_ready), 32'd0);
    check("rec_end_pred_ready", 32'(pred_ready), 32'd1);

    // Not-taken outcome shifted into the restored history.
    enq(32'h3000, 1'b1, 14'h1234);
    res(1'b0);
    check("mp2_re_ghr", 32'(re_GHR), 32'h2468);
    check("mp2_wr_data", 32'(PAs_wr_data), 32'd0);
    check("mp2_cnt", 32'(mp_cnt), 32'd2);
    step();

    // Fill to DEPTH, then resolve while a prediction is offered.
    for (int i = 0; i < 8; i++) enq(32'h4000 + 32'(4 * i), 1'(i % 2), 14'(i));
    check("full_pred_ready", 32'(pred_ready), 32'd0);
    pred_valid = 1'b1;
    pred_pc    = 32'h5000;
    pred_torn  = 1'b0;
    res_valid  = 1'b1;
    res_torn   = 1'b0;
    step();
    pred_valid = 1'b0;
    res_valid  = 1'b0;
    #1;
    check("full_deq_upd_pc", upd_pc, 32'h4000);
    check("full_deq_mispredict", 32'(mispredict), 32'd0);
    check("full_deq_pred_ready", 32'(pred_ready), 32'd1);
    for (int i = 1; i < 8; i++) begin
      res(1'(i % 2));
      check("drain_upd_pc", upd_pc, 32'h4000 + 32'(4 * i));
      check("drain_mispredict", 32'(mispredict), 32'd0);
    end
    check("drain_empty", 32'(res_ready), 32'd0);

    // Resolve offered while empty is ignored.
    res_valid = 1'b1;
    res_torn  = 1'b1;
    #1;
    check("empty_res_ready", 32'(res_ready), 32'd0);
    step();
    res_valid = 1'b0;
    check("empty_pas_up_en", 32'(PAs_up_en), 32'd0);
    check("empty_mispredict", 32'(mispredict), 32'd0);
    check("empty_mp_cnt", 32'(mp_cnt), 32'd2);
    check("empty_idle", 32'(pred_ready), 32'd1);

    // Counter saturation.
    force dut.mp_cnt_q = 16'hFFFF;
    step();
    release dut.mp_cnt_q;
    step();
    check("sat_preload", 32'(mp_cnt), 32'hFFFF);
    enq(32'h6000, 1'b0, 14'h0003);
    res(1'b1);
    check("sat_mispredict", 32'(mispredict), 32'd1);
    check("sat_hold", 32'(mp_cnt), 32'hFFFF);
    step();

    // Reset while recovering.
    enq(32'h7000, 1'b1, 14'h0007);
    enq(32'h7004, 1'b1, 14'h0008);
    res(1'b0);
    check("rr_in_recover", 32'(gshare_reen), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("rr_gshare_reen", 32'(gshare_reen), 32'd0);
    check("rr_mispredict", 32'(mispredict), 32'd0);
    check("rr_fifo_empty", 32'(res_ready), 32'd0);
    check("rr_mp_cnt", 32'(mp_cnt), 32'd0);
    check("rr_re_ghr", 32'(re_GHR), 32'd0);
    check("rr_upd_pc", upd_pc, 32'd0);
    check("rr_pred_ready", 32'(pred_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/branch_update_unit.md
BRANCH_UPDATE_UNIT -- requirements
Module: branch_update_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 8 (power of two, 2..32), the number of in-flight prediction checkpoints.
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous active-high reset.
REQ-004 SHALL have port pred_valid  input  1  predictor issued a conditional-branch prediction this cycle.
REQ-005 SHALL have port pred_pc  input  32  branch address, `ADDR_WIDTH.
REQ-006 SHALL have port pred_torn  input  1  predicted direction, 1 = taken.
REQ-007 SHALL have port pred_ghr  input  14  GHR snapshot at prediction time, `GHR_WIDTH.
REQ-008 SHALL have port pred_tar  input  32  predicted target, `TARGET_ADDR; present only under BRU_TARGET_CHK_EN.
REQ-009 SHALL have port pred_ready  output  1  checkpoint queue can accept an entry.
REQ-010 SHALL have port res_valid  input  1  execute stage resolved the oldest branch.
REQ-011 SHALL have port res_torn  input  1  actual direction.
REQ-012 SHALL have port res_tar  input  32  actual target; present only under BRU_TARGET_CHK_EN.
REQ-013 SHALL have port res_ready  output  1  unit can accept a resolution.
REQ-014 SHALL have port PAs_up_en  output  1  one-cycle BHT/PST update strobe.
REQ-015 SHALL have port PAs_wr_data  output  1  outcome written with PAs_up_en.
REQ-016 SHALL have port upd_pc  output  32  address of the branch being updated.
REQ-017 SHALL have port gshare_reen  output  1  GHR restore strobe.
REQ-018 SHALL have port re_GHR  output  14  GHR value to restore.
REQ-019 SHALL have port mispredict  output  1  one-cycle misprediction/flush pulse.
REQ-020 SHALL have port mp_cnt  output  16  saturating misprediction count.
REQ-021 SHALL have ports up_addr  output  32  corrected target, and up_tar_en  output  1  target write strobe; present only under BRU_TARGET_CHK_EN.

Function
REQ-022 SHALL hold a FIFO of DEPTH entries {pc, torn, ghr[, tar]}; enqueue on pred_valid && pred_ready; pred_ready = !full && state==IDLE.
REQ-023 SHALL NOT enqueue when full even if a dequeue occurs the same cycle; pointers wrap modulo DEPTH; count width $clog2(DEPTH)+1.
REQ-024 SHALL set res_ready = !empty && state==IDLE; a resolution dequeues the head on res_valid && res_ready; res_valid while empty is ignored.
REQ-025 SHALL, one cycle after each accepted resolution, pulse PAs_up_en=1 with PAs_wr_data=res_torn and upd_pc=head pc (registered outputs).
REQ-026 SHALL declare mispredict when res_torn != head torn (or, under BRU_TARGET_CHK_EN, when res_torn=1 and res_tar != head tar).
REQ-027 SHALL use a two-state FSM: IDLE -> RECOVER on mispredicting resolution; RECOVER -> IDLE unconditionally after one cycle.
REQ-028 SHALL, in the RECOVER cycle, drive mispredict=1, gshare_reen=1, re_GHR={head_ghr[12:0], res_torn}, and empty the FIFO (count=0, rd_ptr=wr_ptr).
REQ-029 SHALL discard any enqueue attempted in the mispredicting resolve cycle or the RECOVER cycle (wrong-path).
REQ-030 SHALL increment mp_cnt on each mispredict, holding at 16'hFFFF.
REQ-031 SHALL drive gshare_reen, mispredict, PAs_up_en, up_tar_en to 0 in every cycle other than the one specified.

Reset
REQ-032 SHALL on reset: FIFO empty, pointers 0, state IDLE, all strobes 0, upd_pc/re_GHR/up_addr 0, mp_cnt 0; reset mid-RECOVER aborts the restore.

Configuration
REQ-033 SHALL, with BRU_TARGET_CHK_EN defined, store targets, compare them, and on target mismatch pulse up_tar_en with up_addr=res_tar in the RECOVER cycle.
REQ-034 SHALL, without BRU_TARGET_CHK_EN, omit pred_tar, res_tar, up_addr, up_tar_en and target storage; direction-only checking.

Structure
REQ-035 SHALL take `GHR_WIDTH, `ADDR_WIDTH, `TARGET_ADDR from the shared predictor header; FSM state encodings and checkpoint entry width belong there too.
REQ-036 SHALL instantiate one sub-module, chk_fifo (parameterised FIFO with flush input).

Verification
REQ-037 SHALL cover: enqueue pc=0x1000 torn=1 ghr=0x0005, resolve torn=1 -> next cycle PAs_up_en=1, PAs_wr_data=1, upd_pc=0x1000, mispredict=0.
REQ-038 SHALL cover: enqueue 3 entries, first ghr=0x3FFF torn=0, resolve torn=1 -> RECOVER: gshare_reen=1, re_GHR=0x3FFF, pred_ready=0, FIFO empty, mp_cnt=1.
REQ-039 SHALL cover: DEPTH=8 enqueues -> pred_ready=0; simultaneous pred_valid and resolve while full -> count goes 8 to 7, no enqueue.
REQ-040 SHALL cover: res_valid with empty FIFO -> res_ready=0, no strobes, state unchanged.
REQ-041 SHALL cover: mp_cnt preloaded via 65535 mispredicts (or forced) plus one more -> mp_cnt stays 0xFFFF.
REQ-042 SHALL cover: reset asserted during RECOVER -> gshare_reen=0 next cycle, FIFO empty, mp_cnt=0.
